instruction_fetch: RTL and testbench

- Front end of the Antares-R2 pipeline. Owns the PC and issues word reads to instruction memory over a ready handshake.
- Drives the IF/ID pipeline register, which feeds the decode stage and the control unit. if_id_opcode is instr[31:26].
- Accepts stall requests from hazard logic and PC redirects from the branch/jump resolution logic (taken BEQ/BNE, J, JAL).

---
 rtl/instruction_fetch.sv | 155 +++++++++++++++
 tb/tb_instruction_fetch.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Antares-R2 fetch stage: owns the PC, issues word reads over a ready handshake
// and fills the IF/ID register, honouring stalls and branch/jump redirects.
module instruction_fetch #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  imem_ready,
  output logic                  if_id_valid,
  output logic [DATA_WIDTH-1:0] if_id_instr,
  output logic [ADDR_WIDTH-1:0] if_id_pc4,
  output logic [5:0]            if_id_opcode
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] RESET_PC_AL = {RESET_PC[ADDR_WIDTH-1:2], 2'b00};
  localparam logic [ADDR_WIDTH-1:0] PC_STEP     = ADDR_WIDTH'(4);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]   disc_addr_q, disc_addr_d;
  logic                    active_q, active_d;
  logic                    valid_q, valid_d;
  logic [DATA_WIDTH-1:0]   instr_q, instr_d;
  logic [ADDR_WIDTH-1:0]   pc4_q, pc4_d;
  logic [DATA_WIDTH-1:0]   buf_instr_q, buf_instr_d;
  logic [ADDR_WIDTH-1:0]   buf_pc4_q, buf_pc4_d;

  logic                    req;
  logic                    fetch_done;
  logic [ADDR_WIDTH-1:0]   pc_plus4;
  logic [ADDR_WIDTH-1:0]   redirect_al;
  logic                    unused_redirect_lsbs;

  // active_q keeps the request low for the first cycle out of reset, so a
  // stale ready from memory can never be mistaken for a response.
  assign req          = active_q && (state_q != HOLD);
  assign fetch_done   = req && imem_ready;
  assign pc_plus4     = pc_q + PC_STEP;
  assign redirect_al  = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign imem_req     = req;
  assign imem_addr    = (state_q == DISCARD) ? disc_addr_q : pc_q;
  assign if_id_valid  = valid_q;
  assign if_id_instr  = instr_q;
  assign if_id_pc4    = pc4_q;
  assign if_id_opcode = instr_q[31:26];

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    disc_addr_d = disc_addr_q;
    active_d    = 1'b1;
    valid_d     = valid_q;
    instr_d     = instr_q;
    pc4_d       = pc4_q;
    buf_instr_d = buf_instr_q;
    buf_pc4_d   = buf_pc4_q;

    if (redirect) begin
      pc_d        = redirect_al;
      valid_d     = 1'b0;
      buf_instr_d = '0;
      buf_pc4_d   = '0;
      unique case (state_q)
        FETCH: begin
          // An unanswered request cannot be aborted; remember its address
          // so it is held on the bus until memory responds.
          if (req && !imem_ready) begin
            state_d     = DISCARD;
            disc_addr_d = pc_q;
          end else begin
            state_d = FETCH;
          end
        end
        HOLD:    state_d = FETCH;
        DISCARD: state_d = imem_ready ? FETCH : DISCARD;
        default: state_d = FETCH;
      endcase
    end else begin
      unique case (state_q)
        FETCH: begin
          if (stall) begin
            if (fetch_done) begin
              buf_instr_d = imem_rdata;
              buf_pc4_d   = pc_plus4;
              pc_d        = pc_plus4;
              state_d     = HOLD;
            end
          end else if (fetch_done) begin
            valid_d = 1'b1;
            instr_d = imem_rdata;
            pc4_d   = pc_plus4;
            pc_d    = pc_plus4;
          end else begin
            valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            valid_d     = 1'b1;
            instr_d     = buf_instr_q;
            pc4_d       = buf_pc4_q;
            buf_instr_d = '0;
            buf_pc4_d   = '0;
            state_d     = FETCH;
          end
        end
        DISCARD: begin
          if (imem_ready) state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC_AL;
      disc_addr_q <= '0;
      active_q    <= 1'b0;
      valid_q     <= 1'b0;
      instr_q     <= '0;
      pc4_q       <= '0;
      buf_instr_q <= '0;
      buf_pc4_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      disc_addr_q <= disc_addr_d;
      active_q    <= active_d;
      valid_q     <= valid_d;
      instr_q     <= instr_d;
      pc4_q       <= pc4_d;
      buf_instr_q <= buf_instr_d;
      buf_pc4_q   <= buf_pc4_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: variable-latency memory model, directed
// scenarios plus random stall/redirect/reset, scored against program order.
module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic [5:0]  if_id_opcode;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: fetched addresses follow program order, restarting at
  // the reset PC or at each redirect target.
  logic [31:0] exp_q[$];
  logic [31:0] next_push;
  logic        model_valid = 1'b0;
  logic [31:0] last_addr = 32'h0;
  int          deliv_cnt = 0;

  int          lat_mode = 1;
  logic        junk_ready = 1'b0;

  instruction_fetch #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .imem_ready(imem_ready),
    .if_id_valid(if_id_valid),
    .if_id_instr(if_id_instr),
    .if_id_pc4(if_id_pc4),
    .if_id_opcode(if_id_opcode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) + 32'h1357_9BDF;
  endfunction

  function automatic void refill();
    while (exp_q.size() < 16) begin
      exp_q.push_back(next_push);
      next_push = next_push + 32'd4;
    end
  endfunction

  function automatic void restart(input logic [31:0] a);
    exp_q.delete();
    next_push = a;
    refill();
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    refill();
  endtask

  // Monitor: classifies every edge and pops the scoreboard on each new delivery.
  initial begin
    logic        e_stall;
    logic        e_redir;
    logic [31:0] a;
    logic [31:0] w;
    logic [5:0]  op;
    forever begin
      @(posedge clk);
      e_stall = stall;
      e_redir = redirect;
      #1;
      if (rst) begin
        check_output("rst_valid", {31'b0, if_id_valid}, 32'd0);
        check_output("rst_instr", if_id_instr, 32'd0);
        check_output("rst_pc4", if_id_pc4, 32'd0);
        check_output("rst_req", {31'b0, imem_req}, 32'd0);
        model_valid = 1'b0;
      end else if (e_redir) begin
        check_output("redirect_clears_valid", {31'b0, if_id_valid}, 32'd0);
        model_valid = 1'b0;
      end else if (e_stall) begin
        check_output("stall_hold_valid", {31'b0, if_id_valid}, {31'b0, model_valid});
        if (model_valid) begin
          check_output("stall_hold_instr", if_id_instr, mem_word(last_addr));
          check_output("stall_hold_pc4", if_id_pc4, last_addr + 32'd4);
        end
      end else if (if_id_valid) begin
        if (exp_q.size() == 0) begin
          check_output("sb_expected_available", 32'd0, 32'd1);
        end else begin
          a  = exp_q.pop_front();
          w  = mem_word(a);
          op = w[31:26];
          check_output("sb_instr", if_id_instr, w);
          check_output("sb_pc4", if_id_pc4, a + 32'd4);
          check_output("sb_opcode", {26'b0, if_id_opcode}, {26'b0, op});
          last_addr = a;
        end
        model_valid = 1'b1;
        deliv_cnt++;
      end else begin
        model_valid = 1'b0;
      end
    end
  end

  // Memory model: latency per request, data from the address latched at
  // request start; address must stay put until the response.
  initial begin
    logic        busy;
    logic [31:0] req_addr;
    int          remain;
    busy = 1'b0;
    req_addr = 32'h0;
    remain = 0;
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        busy = 1'b0;
        imem_ready = junk_ready;
        imem_rdata = 32'hDEAD_BEEF ^ $urandom;
      end else if (!imem_req) begin
        if (busy) check_output("req_held_until_ready", 32'd0, 32'd1);
        busy = 1'b0;
        imem_ready = junk_ready;
        imem_rdata = 32'hDEAD_BEEF ^ $urandom;
      end else begin
        if (busy) begin
          check_output("addr_stable", imem_addr, req_addr);
        end else begin
          busy = 1'b1;
          req_addr = imem_addr;
          remain = (lat_mode == 0) ? int'($urandom_range(1, 4)) : lat_mode;
        end
        remain--;
        if (remain <= 0) begin
          imem_ready = 1'b1;
          imem_rdata = mem_word(req_addr);
          busy = 1'b0;
        end else begin
          imem_ready = 1'b0;
          imem_rdata = $urandom;
        end
      end
    end
  end

  task automatic do_reset(input bit check_now);
    rst = 1'b1;
    if (check_now) begin
      #1;
      check_output("async_rst_req", {31'b0, imem_req}, 32'd0);
      check_output("async_rst_valid", {31'b0, if_id_valid}, 32'd0);
      check_output("async_rst_instr", if_id_instr, 32'd0);
      check_output("async_rst_pc4", if_id_pc4, 32'd0);
    end
    stall = 1'b0;
    redirect = 1'b0;
    junk_ready = 1'b1;
    restart(RESET_PC);
    step();
    step();
    rst = 1'b0;
    step();
    junk_ready = 1'b0;
  endtask

  task automatic wait_addr(input logic [31:0] target, input int budget);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (imem_req && imem_addr == target) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check_output("wait_addr_reached", {31'b0, found}, 32'd1);
  endtask

  task automatic wait_delivery(input int budget);
    int d0;
    d0 = deliv_cnt;
    for (int i = 0; i < budget && deliv_cnt == d0; i++) step();
    check_output("delivery_within_budget", {31'b0, deliv_cnt != d0}, 32'd1);
  endtask

  task automatic apply_stimulus(input int cycles);
    logic [31:0] t;
    for (int i = 0; i < cycles; i++) begin
      step();
      stall = ($urandom_range(0, 3) == 0);
      redirect = 1'b0;
      junk_ready = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 19) == 0) begin
        t = $urandom;
        if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
        redirect = 1'b1;
        redirect_pc = t;
        restart({t[31:2], 2'b00});
      end
      if ($urandom_range(0, 199) == 0) begin
        redirect = 1'b0;
        rst = 1'b1;
        restart(RESET_PC);
        step();
        rst = 1'b0;
      end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d0;
    rst = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;

    // Reset release and single-cycle memory throughput.
    lat_mode = 1;
    do_reset(1'b0);
    check_output("first_req", {31'b0, imem_req}, 32'd1);
    check_output("first_addr", imem_addr, RESET_PC);
    check_output("first_valid_low", {31'b0, if_id_valid}, 32'd0);
    step();
    check_output("cycle2_valid", {31'b0, if_id_valid}, 32'd1);
    check_output("cycle2_pc4", if_id_pc4, RESET_PC + 32'd4);
    d0 = deliv_cnt;
    repeat (16) step();
    check_output("throughput_lat1", deliv_cnt - d0, 32'd16);

    // Three-cycle memory: one instruction every third cycle.
    lat_mode = 3;
    repeat (8) step();
    d0 = deliv_cnt;
    repeat (30) step();
    check_output("throughput_lat3", deliv_cnt - d0, 32'd10);

    // Stall while the word at 0x10 returns.
    lat_mode = 1;
    do_reset(1'b0);
    wait_addr(32'h10, 20);
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_output("hold_req_low", {31'b0, imem_req}, 32'd0);
      check_output("hold_ifid_pc4", if_id_pc4, 32'h10);
    end
    stall = 1'b0;
    step();
    check_output("release_instr", if_id_instr, mem_word(32'h10));
    check_output("release_pc4", if_id_pc4, 32'h14);
    check_output("release_next_addr", imem_addr, 32'h14);
    check_output("release_next_req", {31'b0, imem_req}, 32'd1);

    // Redirect while a slow fetch at 0x20 is outstanding.
    lat_mode = 3;
    do_reset(1'b0);
    wait_addr(32'h20, 60);
    redirect = 1'b1;
    redirect_pc = 32'h40;
    restart(32'h40);
    step();
    redirect = 1'b0;
    check_output("discard_req", {31'b0, imem_req}, 32'd1);
    check_output("discard_addr_held", imem_addr, 32'h20);
    check_output("discard_valid", {31'b0, if_id_valid}, 32'd0);
    wait_addr(32'h40, 10);
    wait_delivery(10);
    check_output("redirect_first_addr", last_addr, 32'h40);

    // Misaligned redirect together with stall and ready.
    lat_mode = 1;
    do_reset(1'b0);
    for (int i = 0; i < 20 && deliv_cnt < 3; i++) step();
    stall = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h43;
    restart(32'h40);
    step();
    redirect = 1'b0;
    check_output("redir_stall_valid", {31'b0, if_id_valid}, 32'd0);
    check_output("redir_stall_req", {31'b0, imem_req}, 32'd1);
    check_output("redir_stall_addr", imem_addr, 32'h40);
    step();
    stall = 1'b0;
    wait_delivery(10);
    check_output("redir_stall_first", last_addr, 32'h40);

    // Reset while in HOLD, then PC wrap-around.
    wait_addr(32'h48, 20);
    stall = 1'b1;
    step();
    check_output("pre_reset_hold_req", {31'b0, imem_req}, 32'd0);
    do_reset(1'b1);
    check_output("restart_addr", imem_addr, RESET_PC);
    wait_delivery(10);
    check_output("restart_first", last_addr, RESET_PC);

    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    restart(32'hFFFF_FFF8);
    step();
    redirect = 1'b0;
    for (int i = 0; i < 20 && last_addr != 32'hFFFF_FFFC; i++) step();
    check_output("wrap_last_fetched", last_addr, 32'hFFFF_FFFC);
    check_output("wrap_next_addr", imem_addr, 32'h0);
    wait_delivery(10);
    check_output("wrap_first", last_addr, 32'h0);

    // Randomised stalls, redirects, latencies and resets.
    lat_mode = 0;
    d0 = deliv_cnt;
    apply_stimulus(3000);
    stall = 1'b0;
    redirect = 1'b0;
    repeat (10) step();
    check_output("random_progress", {31'b0, (deliv_cnt - d0) > 300}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
